// File: rtl/noc_flit_pkg.sv
`default_nettype none
// =============================================================================
// noc_flit_pkg -- shared 20-bit NoC flit layout and field helpers  | Rev 1.0
// =============================================================================
package noc_flit_pkg;

   localparam int FLIT_W      = 20;
   localparam int PAYLOAD_MSB = 19;
   localparam int PAYLOAD_LSB = 4;
   localparam int PAYLOAD_W   = PAYLOAD_MSB - PAYLOAD_LSB + 1;
   localparam int CLUSTER_MSB = 3;
   localparam int CLUSTER_LSB = 2;
   localparam int LOCAL_MSB   = 1;
   localparam int LOCAL_LSB   = 0;

   typedef logic [FLIT_W-1:0]    flit_t;
   typedef logic [PAYLOAD_W-1:0] payload_t;

   function automatic payload_t flit_payload(input flit_t f);
      return f[PAYLOAD_MSB:PAYLOAD_LSB];
   endfunction

   function automatic logic [1:0] flit_cluster(input flit_t f);
      return f[CLUSTER_MSB:CLUSTER_LSB];
   endfunction

   function automatic logic [1:0] flit_local(input flit_t f);
      return f[LOCAL_MSB:LOCAL_LSB];
   endfunction

   function automatic logic flit_dest_match(input flit_t f, input logic [1:0] cl,
                                            input logic [1:0] lo);
      return (flit_cluster(f) == cl) && (flit_local(f) == lo);
   endfunction

endpackage
`default_nettype wire

// File: rtl/datain_sink_node_if.sv
`default_nettype none
// =============================================================================
// datain_sink_node_if -- valid-only flit ingress bundle  | Rev 1.0
// =============================================================================
interface datain_sink_node_if;
   import noc_flit_pkg::*;

   logic  in_valid;
   flit_t datain;
   logic  in_ready;

   modport master (output in_valid, output datain, input  in_ready);
   modport slave  (input  in_valid, input  datain, output in_ready);
endinterface
`default_nettype wire

// File: rtl/sink_fifo.sv
`default_nettype none
// =============================================================================
// sink_fifo -- synchronous FIFO, power-of-2 depth, separate occupancy count  | Rev 1.0
// =============================================================================
module sink_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 20
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     i_push,
   input  wire logic [WIDTH-1:0]         i_din,
   input  wire logic                     i_pop,
   output logic      [WIDTH-1:0]         o_dout,
   output logic                          o_full,
   output logic                          o_empty,
   output logic      [$clog2(DEPTH):0]   o_count
);
   localparam int           AW     = $clog2(DEPTH);
   localparam logic [AW:0]  C_FULL = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == C_FULL);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/datain_sink_node.sv
`default_nettype none
// =============================================================================
// datain_sink_node -- NoC ejection sink: FIFO, drain FSM, destination stats.
// Optional payload checksum: DATAIN_SINK_CHECKSUM_EN  | Rev 1.0
// =============================================================================
module datain_sink_node
   import noc_flit_pkg::*;
#(
   parameter int MY_CLUSTER   = 0,
   parameter int MY_LOCAL     = 0,
   parameter int FIFO_DEPTH   = 4,
   parameter int DRAIN_GAP    = 0,
   parameter int EXPECT_COUNT = 30
) (
   input  wire logic          clk,
   input  wire logic          rst,
   datain_sink_node_if.slave  in_bus,
   input  wire logic          enable,
   output logic [15:0]        rx_count,
   output logic [7:0]         misroute_count,
   output logic [7:0]         drop_count,
   output logic [15:0]        last_payload,
   output logic [15:0]        payload_sum,
   output logic               done
);
   localparam int          AW         = $clog2(FIFO_DEPTH);
   localparam logic [1:0]  C_MY_CL    = MY_CLUSTER[1:0];
   localparam logic [1:0]  C_MY_LO    = MY_LOCAL[1:0];
   localparam logic [7:0]  C_GAP_LOAD = (DRAIN_GAP > 0) ? 8'(DRAIN_GAP - 1) : 8'd0;
   localparam logic [31:0] C_EXPECT   = 32'(EXPECT_COUNT);
   localparam logic [AW:0] C_ONE      = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e      r_state, w_state_nxt;
   logic [7:0]  r_gap, w_gap_nxt;
   logic [31:0] r_drained;
   logic [15:0] r_rx, r_last;
   logic [7:0]  r_mis, r_drop;
   flit_t       w_head;
   logic        w_full, w_empty, w_pop, w_push, w_match, w_more, w_tally_hit;
   logic [AW:0] w_count;

   sink_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FLIT_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (in_bus.in_valid),
      .i_din   (in_bus.datain),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign in_bus.in_ready = !w_full;
   assign w_push      = in_bus.in_valid && !w_full;
   assign w_pop       = (r_state == S_POP) && !w_empty;
   assign w_match     = flit_dest_match(w_head, C_MY_CL, C_MY_LO);
   // Occupancy after this cycle's pop: something left or arriving now.
   assign w_more      = (w_count > C_ONE) || w_push;
   assign w_tally_hit = w_pop && ((r_drained + 32'd1) == C_EXPECT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      case (r_state)
         S_IDLE: if (enable && !w_empty) w_state_nxt = S_POP;
         S_POP: begin
            if (w_tally_hit) begin
               w_state_nxt = S_DONE;
            end else if (DRAIN_GAP > 0) begin
               w_state_nxt = S_GAP;
               w_gap_nxt   = C_GAP_LOAD;
            end else if (enable && w_more) begin
               w_state_nxt = S_POP;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            if (enable) begin
               if (r_gap == 8'd0) w_state_nxt = S_IDLE;
               else               w_gap_nxt   = r_gap - 8'd1;
            end
         end
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drained <= '0;
         r_rx      <= '0;
         r_mis     <= '0;
         r_drop    <= '0;
         r_last    <= '0;
      end else begin
         // Full is judged on pre-edge occupancy, so a same-cycle pop never rescues.
         if (in_bus.in_valid && w_full && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
         if (w_pop) begin
            r_drained <= r_drained + 32'd1;
            if (w_match) begin
               if (r_rx != 16'hFFFF) r_rx <= r_rx + 16'd1;
               r_last <= flit_payload(w_head);
            end else if (r_mis != 8'hFF) begin
               r_mis <= r_mis + 8'd1;
            end
         end
      end
   end

`ifdef DATAIN_SINK_CHECKSUM_EN
   logic [15:0] r_sum;
   always_ff @(posedge clk) begin
      if (rst)                    r_sum <= '0;
      else if (w_pop && w_match)  r_sum <= r_sum + flit_payload(w_head);
   end
   assign payload_sum = r_sum;
`else
   assign payload_sum = 16'd0;
`endif

   assign rx_count       = r_rx;
   assign misroute_count = r_mis;
   assign drop_count     = r_drop;
   assign last_payload   = r_last;
   assign done           = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_datain_sink_node.sv
`default_nettype none
// =============================================================================
// tb_datain_sink_node -- self-checking bench for datain_sink_node  | Rev 1.0
// =============================================================================
module tb_datain_sink_node;
   import noc_flit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_q [4];
   logic        v     [4];
   logic [19:0] d     [4];
   logic        en    [4];
   logic        rdy   [4];
   logic [15:0] rx    [4];
   logic [7:0]  mis   [4];
   logic [7:0]  drp   [4];
   logic [15:0] lp    [4];
   logic [15:0] ps    [4];
   logic        dn    [4];

   int errors = 0;
   int checks = 0;

   datain_sink_node_if b0 ();
   datain_sink_node_if b1 ();
   datain_sink_node_if b2 ();
   datain_sink_node_if b3 ();

   assign b0.in_valid = v[0]; assign b0.datain = d[0]; assign rdy[0] = b0.in_ready;
   assign b1.in_valid = v[1]; assign b1.datain = d[1]; assign rdy[1] = b1.in_ready;
   assign b2.in_valid = v[2]; assign b2.datain = d[2]; assign rdy[2] = b2.in_ready;
   assign b3.in_valid = v[3]; assign b3.datain = d[3]; assign rdy[3] = b3.in_ready;

   datain_sink_node u0 (
      .clk(clk), .rst(rst_q[0]), .in_bus(b0), .enable(en[0]),
      .rx_count(rx[0]), .misroute_count(mis[0]), .drop_count(drp[0]),
      .last_payload(lp[0]), .payload_sum(ps[0]), .done(dn[0]));

   datain_sink_node #(.MY_LOCAL(1), .EXPECT_COUNT(28)) u1 (
      .clk(clk), .rst(rst_q[1]), .in_bus(b1), .enable(en[1]),
      .rx_count(rx[1]), .misroute_count(mis[1]), .drop_count(drp[1]),
      .last_payload(lp[1]), .payload_sum(ps[1]), .done(dn[1]));

   datain_sink_node #(.DRAIN_GAP(3)) u2 (
      .clk(clk), .rst(rst_q[2]), .in_bus(b2), .enable(en[2]),
      .rx_count(rx[2]), .misroute_count(mis[2]), .drop_count(drp[2]),
      .last_payload(lp[2]), .payload_sum(ps[2]), .done(dn[2]));

   datain_sink_node #(.MY_CLUSTER(1), .EXPECT_COUNT(400)) u3 (
      .clk(clk), .rst(rst_q[3]), .in_bus(b3), .enable(en[3]),
      .rx_count(rx[3]), .misroute_count(mis[3]), .drop_count(drp[3]),
      .last_payload(lp[3]), .payload_sum(ps[3]), .done(dn[3]));

   typedef struct {
      logic [19:0] flit;
      int          exp_rx;
      int          exp_mis;
      logic [15:0] exp_last;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic pulse_rst(input int i);
      rst_q[i] = 1'b1;
      tick();
      rst_q[i] = 1'b0;
   endtask

   task automatic send(input int i, input logic [19:0] f);
      v[i] = 1'b1;
      d[i] = f;
      tick();
      v[i] = 1'b0;
   endtask

   function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef DATAIN_SINK_CHECKSUM_EN
      return s;
`else
      return 16'd0;
`endif
   endfunction

   initial begin
      vec_t        vecs [8];
      logic [15:0] m_sum;
      int          m_rx, m_mis, n;
      logic [15:0] m_last, pl;
      logic [1:0]  dc, dl;
      logic        saw_low;

      vecs[0] = '{20'h12340, 1, 0, 16'h1234};
      vecs[1] = '{20'hABCD1, 1, 1, 16'h1234};
      vecs[2] = '{20'h0FFF4, 1, 2, 16'h1234};
      vecs[3] = '{20'hFFFF0, 2, 2, 16'hFFFF};
      vecs[4] = '{20'h00003, 2, 3, 16'hFFFF};
      vecs[5] = '{20'h00000, 3, 3, 16'h0000};
      vecs[6] = '{20'h5555C, 3, 4, 16'h0000};
      vecs[7] = '{20'h7E570, 4, 4, 16'h7E57};

      for (int i = 0; i < 4; i++) begin
         rst_q[i] = 1'b1; v[i] = 1'b0; d[i] = '0; en[i] = 1'b1;
      end
      ticks(2);
      for (int i = 0; i < 4; i++) rst_q[i] = 1'b0;

      chk("reset_in_ready", 32'(rdy[0]), 32'd1);
      chk("reset_rx",       32'(rx[0]),  32'd0);
      chk("reset_mis",      32'(mis[0]), 32'd0);
      chk("reset_drop",     32'(drp[0]), 32'd0);
      chk("reset_last",     32'(lp[0]),  32'd0);
      chk("reset_sum",      32'(ps[0]),  32'd0);
      chk("reset_done",     32'(dn[0]),  32'd0);

      // Single-flit table on the default node.
      m_sum = '0;
      for (int t = 0; t < 8; t++) begin
         send(0, vecs[t].flit);
         ticks(3);
         chk($sformatf("vec%0d_rx", t),   32'(rx[0]),  32'(vecs[t].exp_rx));
         chk($sformatf("vec%0d_mis", t),  32'(mis[0]), 32'(vecs[t].exp_mis));
         chk($sformatf("vec%0d_last", t), 32'(lp[0]),  32'(vecs[t].exp_last));
         if (vecs[t].flit[3:0] == 4'h0) m_sum = m_sum + vecs[t].flit[19:4];
      end
      chk("vec_sum", 32'(ps[0]), 32'(exp_sum(m_sum)));

      // 30 back-to-back flits to 0/0.
      pulse_rst(0);
      for (int k = 1; k <= 30; k++) begin
         v[0] = 1'b1; d[0] = 20'(k << 4); tick();
      end
      v[0] = 1'b0;
      ticks(5);
      chk("b2b_rx",   32'(rx[0]),  32'd30);
      chk("b2b_mis",  32'(mis[0]), 32'd0);
      chk("b2b_drop", 32'(drp[0]), 32'd0);
      chk("b2b_last", 32'(lp[0]),  32'h1E);
      chk("b2b_done", 32'(dn[0]),  32'd1);
      chk("b2b_sum",  32'(ps[0]),  32'(exp_sum(16'h01D1)));
      // After done the FIFO fills then drops.
      for (int k = 0; k < 6; k++) begin
         v[0] = 1'b1; d[0] = 20'h00110; tick();
      end
      v[0] = 1'b0;
      ticks(2);
      chk("post_done_drop",  32'(drp[0]), 32'd2);
      chk("post_done_ready", 32'(rdy[0]), 32'd0);
      chk("post_done_rx",    32'(rx[0]),  32'd30);

      // Enable held low, then raised.
      pulse_rst(0);
      en[0] = 1'b0;
      send(0, 20'h00010); send(0, 20'h00020); send(0, 20'h00030);
      ticks(4);
      chk("en_low_rx",    32'(rx[0]),  32'd0);
      chk("en_low_ready", 32'(rdy[0]), 32'd1);
      en[0] = 1'b1;
      tick();
      chk("en_e1_rx", 32'(rx[0]), 32'd0);
      tick();
      chk("en_e2_rx", 32'(rx[0]), 32'd1);
      tick();
      chk("en_e3_rx", 32'(rx[0]), 32'd2);
      tick();
      chk("en_e4_rx", 32'(rx[0]), 32'd3);
      chk("en_last",  32'(lp[0]), 32'h3);

      // Mid-operation reset discards queued flits.
      pulse_rst(0);
      en[0] = 1'b0;
      for (int k = 0; k < 4; k++) send(0, 20'h00050);
      en[0] = 1'b1;
      ticks(3);
      chk("prerst_rx", 32'(rx[0]), 32'd2);
      rst_q[0] = 1'b1;
      tick();
      rst_q[0] = 1'b0;
      chk("midrst_rx",    32'(rx[0]),  32'd0);
      chk("midrst_last",  32'(lp[0]),  32'd0);
      chk("midrst_sum",   32'(ps[0]),  32'd0);
      chk("midrst_ready", 32'(rdy[0]), 32'd1);
      chk("midrst_done",  32'(dn[0]),  32'd0);
      ticks(8);
      chk("midrst_residual_rx",  32'(rx[0]),  32'd0);
      chk("midrst_residual_mis", 32'(mis[0]), 32'd0);

      // MY_LOCAL=1 node, 28 mixed flits.
      for (int k = 0; k < 28; k++) begin
         v[1] = 1'b1; d[1] = 20'(32'h10 + (k % 4) * 32'h11); tick();
      end
      v[1] = 1'b0;
      ticks(5);
      chk("ml1_rx",   32'(rx[1]),  32'd7);
      chk("ml1_mis",  32'(mis[1]), 32'd21);
      chk("ml1_done", 32'(dn[1]),  32'd1);
      chk("ml1_last", 32'(lp[1]),  32'h2);

      // Slow consumer overflows the FIFO.
      saw_low = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         v[2] = 1'b1; d[2] = 20'(k << 4); tick();
         if (rdy[2] == 1'b0) saw_low = 1'b1;
      end
      v[2] = 1'b0;
      ticks(30);
      chk("gap_ready_fell", 32'(saw_low), 32'd1);
      chk("gap_drop",  32'(drp[2]), 32'd4);
      chk("gap_rx",    32'(rx[2]),  32'd6);
      chk("gap_mis",   32'(mis[2]), 32'd0);
      chk("gap_ready", 32'(rdy[2]), 32'd1);

      // Misroute saturation.
      for (int k = 0; k < 300; k++) begin
         v[3] = 1'b1; d[3] = 20'h00010; tick();
      end
      v[3] = 1'b0;
      ticks(5);
      chk("sat_mis",  32'(mis[3]), 32'd255);
      chk("sat_rx",   32'(rx[3]),  32'd0);
      chk("sat_drop", 32'(drp[3]), 32'd0);
      chk("sat_done", 32'(dn[3]),  32'd0);

      // Randomized traffic against a count-level reference model.
      for (int r = 0; r < 8; r++) begin
         pulse_rst(0);
         n = (r == 7) ? 30 : int'($urandom_range(1, 25));
         m_rx = 0; m_mis = 0; m_last = '0; m_sum = '0;
         for (int k = 0; k < n; k++) begin
            pl = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
               dc = 2'd0; dl = 2'd0;
            end else begin
               dc = 2'($urandom_range(0, 3));
               dl = 2'($urandom_range(1, 3));
            end
            send(0, {pl, dc, dl});
            if (dc == 2'd0 && dl == 2'd0) begin
               m_rx++; m_last = pl; m_sum = m_sum + pl;
            end else begin
               m_mis++;
            end
            ticks($urandom_range(0, 2));
         end
         ticks(5);
         chk($sformatf("rnd%0d_rx", r),   32'(rx[0]),  32'(m_rx));
         chk($sformatf("rnd%0d_mis", r),  32'(mis[0]), 32'(m_mis));
         chk($sformatf("rnd%0d_last", r), 32'(lp[0]),  32'(m_last));
         chk($sformatf("rnd%0d_sum", r),  32'(ps[0]),  32'(exp_sum(m_sum)));
         chk($sformatf("rnd%0d_drop", r), 32'(drp[0]), 32'd0);
         chk($sformatf("rnd%0d_done", r), 32'(dn[0]),  32'(n >= 30));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
